// File: rtl/write_back.sv
// write_back: two-stage write-back (capture, then commit) into a register file
// with a bypass of the pending write and a count of committed writes.
module write_back #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic [31:0]               i_mem_data,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic                      i_ctr_wb_MR,
    input  logic                      i_ctr_wb_RW,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_dest,
    input  logic                      i_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0] i_rf_raddr_a,
    input  logic [REG_ADDR_WIDTH-1:0] i_rf_raddr_b,
    output logic [DATA_WIDTH-1:0]     o_rf_rdata_a,
    output logic [DATA_WIDTH-1:0]     o_rf_rdata_b,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_dest_out,
    output logic                      o_wb_valid,
    output logic [15:0]               o_retired_count
);
    localparam int NREG = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     r_rf [NREG];
    logic [DATA_WIDTH-1:0]     r_wb_data;
    logic [REG_ADDR_WIDTH-1:0] r_wb_dest;
    logic                      r_wb_valid;
    logic [15:0]               r_count;
    logic [DATA_WIDTH-1:0]     w_sel;

    assign w_sel = i_ctr_wb_MR ? i_mem_data[DATA_WIDTH-1:0] : i_alu_result;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            r_wb_data  <= '0;
            r_wb_dest  <= '0;
            r_wb_valid <= 1'b0;
            r_count    <= '0;
        end else if (i_enable) begin
            r_wb_data  <= w_sel;
            r_wb_dest  <= i_wb_dest;
            r_wb_valid <= i_valid_in & i_ctr_wb_RW & (i_wb_dest != '0);
            // Commit uses the previously captured write; r_wb_valid already excludes register 0.
            if (r_wb_valid) begin
                r_rf[r_wb_dest] <= r_wb_data;
                r_count         <= r_count + 16'd1;
            end
        end
    end

    assign o_rf_rdata_a    = (i_rf_raddr_a == '0) ? '0 :
                             (r_wb_valid && i_rf_raddr_a == r_wb_dest) ? r_wb_data : r_rf[i_rf_raddr_a];
    assign o_rf_rdata_b    = (i_rf_raddr_b == '0) ? '0 :
                             (r_wb_valid && i_rf_raddr_b == r_wb_dest) ? r_wb_data : r_rf[i_rf_raddr_b];
    assign o_wb_data       = r_wb_data;
    assign o_wb_dest_out   = r_wb_dest;
    assign o_wb_valid      = r_wb_valid;
    assign o_retired_count = r_count;
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed vector table plus hand-written stall, reset and
// counter-wrap sequences for write_back.
module tb_write_back;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] mem_data = '0;
    logic [15:0] alu_result = '0;
    logic        mr = 1'b0, rw = 1'b0, vld = 1'b0;
    logic [2:0]  dest = '0, ra = '0, rb = '0;
    logic [15:0] rda, rdb, wb_data, cnt;
    logic [2:0]  wb_dest_out;
    logic        wb_valid;
    int          n_tests = 0, n_fail = 0;

    write_back dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mem_data(mem_data),
        .i_alu_result(alu_result), .i_ctr_wb_MR(mr), .i_ctr_wb_RW(rw), .i_wb_dest(dest),
        .i_valid_in(vld), .i_rf_raddr_a(ra), .i_rf_raddr_b(rb), .o_rf_rdata_a(rda),
        .o_rf_rdata_b(rdb), .o_wb_data(wb_data), .o_wb_dest_out(wb_dest_out),
        .o_wb_valid(wb_valid), .o_retired_count(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr, rw, vld;
        logic [2:0]  dest;
        logic [15:0] alu;
        logic [31:0] mem;
        logic [2:0]  ra, rb;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  edst;
        logic [15:0] era, erb, ecnt;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic w, input logic v, input logic [2:0] d,
                         input logic [15:0] a, input logic [31:0] md);
        mr = m; rw = w; vld = v; dest = d; alu_result = a; mem_data = md;
    endtask

    task automatic chk_frozen(input string name);
        chk({name, "_valid"}, 32'(wb_valid), 32'd1);
        chk({name, "_data"}, 32'(wb_data), 32'h2);
        chk({name, "_dest"}, 32'(wb_dest_out), 32'd2);
        chk({name, "_cnt"}, 32'(cnt), 32'd5);
        chk({name, "_bypass"}, 32'(rda), 32'h2);
    endtask

    initial begin
        tv[0] = '{1'b0, 1'b1, 1'b1, 3'd3, 16'h1234, 32'h0, 3'd3, 3'd0, 1'b1, 16'h1234, 3'd3, 16'h1234, 16'h0, 16'd0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 3'd5, 16'h0, 32'hABCDF00F, 3'd3, 3'd5, 1'b1, 16'hF00F, 3'd5, 16'h1234, 16'hF00F, 16'd1};
        tv[2] = '{1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 32'h0, 3'd0, 3'd5, 1'b0, 16'hFFFF, 3'd0, 16'h0, 16'hF00F, 16'd2};
        tv[3] = '{1'b0, 1'b1, 1'b0, 3'd6, 16'h5555, 32'h0, 3'd6, 3'd3, 1'b0, 16'h5555, 3'd6, 16'h0, 16'h1234, 16'd2};
        tv[4] = '{1'b1, 1'b0, 1'b1, 3'd6, 16'h0, 32'h00007777, 3'd6, 3'd5, 1'b0, 16'h7777, 3'd6, 16'h0, 16'hF00F, 16'd2};
        tv[5] = '{1'b0, 1'b1, 1'b1, 3'd7, 16'h0A0A, 32'h0, 3'd7, 3'd7, 1'b1, 16'h0A0A, 3'd7, 16'h0A0A, 16'h0A0A, 16'd2};
        tv[6] = '{1'b0, 1'b1, 1'b1, 3'd7, 16'h0B0B, 32'h0, 3'd7, 3'd3, 1'b1, 16'h0B0B, 3'd7, 16'h0B0B, 16'h1234, 16'd3};
        tv[7] = '{1'b0, 1'b1, 1'b0, 3'd7, 16'h0, 32'h0, 3'd7, 3'd0, 1'b0, 16'h0, 3'd7, 16'h0B0B, 16'h0, 16'd4};

        // Reset state, before any clock edge
        ra = 3'd3; rb = 3'd5;
        #3;
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_data", 32'(wb_data), 32'd0);
        chk("rst_dest", 32'(wb_dest_out), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_rda", 32'(rda), 32'd0);
        #9 rst_n = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(tv[i].mr, tv[i].rw, tv[i].vld, tv[i].dest, tv[i].alu, tv[i].mem);
            step();
            ra = tv[i].ra; rb = tv[i].rb;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(wb_valid), 32'(tv[i].ev));
            chk($sformatf("v%0d_data", i), 32'(wb_data), 32'(tv[i].ed));
            chk($sformatf("v%0d_dest", i), 32'(wb_dest_out), 32'(tv[i].edst));
            chk($sformatf("v%0d_rda", i), 32'(rda), 32'(tv[i].era));
            chk($sformatf("v%0d_rdb", i), 32'(rdb), 32'(tv[i].erb));
            chk($sformatf("v%0d_cnt", i), 32'(cnt), 32'(tv[i].ecnt));
        end

        // Back-to-back writes to reg 2 with a three-cycle stall after the second
        ra = 3'd2; rb = 3'd2;
        drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h1, 32'h0); step();
        drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h2, 32'h0); step();
        chk_frozen("stall_pre");
        enable = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h9999, 32'h8888);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_frozen($sformatf("stall%0d", i));
        end
        enable = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h3, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0); step();
        chk("b2b_reg2", 32'(rda), 32'h3);
        chk("b2b_cnt", 32'(cnt), 32'd7);
        chk("b2b_valid", 32'(wb_valid), 32'd0);

        // Reset mid-cycle with a pending write to reg 4
        ra = 3'd4; rb = 3'd3;
        drive(1'b0, 1'b1, 1'b1, 3'd4, 16'h4444, 32'h0); step();
        chk("pre_rst_valid", 32'(wb_valid), 32'd1);
        chk("pre_rst_bypass", 32'(rda), 32'h4444);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(wb_valid), 32'd0);
        chk("arst_data", 32'(wb_data), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_rda", 32'(rda), 32'd0);
        chk("arst_rdb", 32'(rdb), 32'd0);
        step();
        chk("arst_hold_valid", 32'(wb_valid), 32'd0);
        #3 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        step(); step();
        chk("post_rst_reg4", 32'(rda), 32'd0);
        chk("post_rst_cnt", 32'(cnt), 32'd0);

        // Counter wrap: 65536 edges of writes to reg 1 give 65535 commits
        drive(1'b0, 1'b1, 1'b1, 3'd1, 16'hBEEF, 32'h0);
        repeat (65536) @(posedge clk);
        #1;
        chk("cnt_ffff", 32'(cnt), 32'hFFFF);
        step();
        chk("cnt_wrap", 32'(cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
